seq_chunk_adder: RTL and testbench

- Multi-cycle parametrised adder/subtractor for the datapath ALU.
- Adds or subtracts two WIDTH-bit operands by processing one CHUNK-bit slice per clock, carry rippling between slices through a registered carry.
- Start/done handshake; produces a WIDTH+1-bit result with carry-out in the MSB, plus signed overflow and zero flags.
- Replaces the fixed single-cycle 32-bit adder in paths that trade latency for area.

---
 rtl/seq_chunk_adder_if.sv | 26 ++
 rtl/seq_chunk_adder.sv | 141 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for seq_chunk_adder.
// The master drives the request and operands; the slave (the adder) returns
// status and result.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   S;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, overflow, zero
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, overflow, zero
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, with the carry
// held in a register between slices. The result has the carry-out in its MSB.
// The overflow and zero flags are also produced. For subtraction the B operand
// is inverted when it is captured, and the carry register is seeded with 1.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_chunk_adder_if.slave  bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_bx;
  logic              r_carry;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH:0]    r_s;
  logic              r_ovf;
  logic              r_zero;
  logic              r_zacc;

  logic              w_accept;
  logic              w_last;
  logic [CHUNK-1:0]  w_a_sl;
  logic [CHUNK-1:0]  w_b_sl;
  logic [CHUNK:0]    w_sum;

  // A new request is taken whenever the slice engine is not running.
  assign w_accept = bus.start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == CW'(N - 1));

  // Next-state decision for the IDLE / RUN / DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_RUN;
        else           w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (bus.start) w_state_nxt = ST_RUN;
        else           w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the upcoming state, so they register cleanly.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_RUN:  w_busy_nxt = 1'b1;
      ST_DONE: w_done_nxt = 1'b1;
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Select the current slice and add it, keeping the full CHUNK+1 bits for the carry.
  always_comb begin
    w_a_sl = r_a[r_cnt * CHUNK +: CHUNK];
    w_b_sl = r_bx[r_cnt * CHUNK +: CHUNK];
    w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
  end

  // Operand capture on accept. Each RUN cycle writes one result slice; the last slice also sets the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_bx    <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_s     <= {(WIDTH + 1){1'b0}};
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_zacc  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.A;
      r_bx    <= bus.sub ? ~bus.B : bus.B;
      r_carry <= bus.sub;
      r_cnt   <= {CW{1'b0}};
      r_zacc  <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_s[r_cnt * CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_carry <= w_sum[CHUNK];
      r_zacc  <= r_zacc && (w_sum[CHUNK-1:0] == {CHUNK{1'b0}});
      if (w_last) begin
        r_cnt      <= {CW{1'b0}};
        r_s[WIDTH] <= w_sum[CHUNK];
        r_ovf      <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]);
        r_zero     <= r_zacc && (w_sum[CHUNK-1:0] == {CHUNK{1'b0}});
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.S        = r_s;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK = 16, 8, 32) share the same
// stimulus. Results are compared against arithmetic expectations.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        t_start;
  logic        t_sub;
  logic [31:0] t_a;
  logic [31:0] t_b;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(32)) b16 ();
  seq_chunk_adder_if #(.WIDTH(32)) b8  ();
  seq_chunk_adder_if #(.WIDTH(32)) b32 ();

  assign b16.start = t_start; assign b16.sub = t_sub; assign b16.A = t_a; assign b16.B = t_b;
  assign b8.start  = t_start; assign b8.sub  = t_sub; assign b8.A  = t_a; assign b8.B  = t_b;
  assign b32.start = t_start; assign b32.sub = t_sub; assign b32.A = t_a; assign b32.B = t_b;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] s;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: unsigned sum / difference-with-borrow. Signed overflow is judged by range.
  task automatic model(input logic sub, input logic [31:0] a, input logic [31:0] b,
                       output logic [32:0] s, output logic ovf, output logic zero);
    longint r;
    if (sub) begin
      s = {(a >= b) ? 1'b1 : 1'b0, a - b};
      r = longint'($signed(a)) - longint'($signed(b));
    end else begin
      s = {1'b0, a} + {1'b0, b};
      r = longint'($signed(a)) + longint'($signed(b));
    end
    ovf  = (r != longint'($signed(s[31:0])));
    zero = (s[31:0] == 32'd0);
  endtask

  task automatic sample_dut(input string tag, input int n, input int e,
                            input logic dn, input logic bs, input logic [32:0] s,
                            input logic ov, input logic zr,
                            input logic [32:0] es, input logic eo, input logic ez);
    if (e <= n) begin
      chk({tag, " done(run)"}, {32'd0, dn}, 33'd0);
      chk({tag, " busy(run)"}, {32'd0, bs}, 33'd1);
    end else if (e == n + 1) begin
      chk({tag, " done"}, {32'd0, dn}, 33'd1);
      chk({tag, " busy(done)"}, {32'd0, bs}, 33'd0);
      chk({tag, " S"}, s, es);
      chk({tag, " overflow"}, {32'd0, ov}, {32'd0, eo});
      chk({tag, " zero"}, {32'd0, zr}, {32'd0, ez});
    end else if (e == n + 2) begin
      chk({tag, " done(after)"}, {32'd0, dn}, 33'd0);
    end
  endtask

  // One accepted op; all three instances are checked against their own latency.
  task automatic run_op(input string tag, input logic sub, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] es, input logic eo, input logic ez);
    t_sub = sub; t_a = a; t_b = b; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0; t_a = $urandom; t_b = $urandom; t_sub = ~sub;
    for (int e = 2; e <= 6; e++) begin
      @(posedge clk); #1;
      sample_dut({tag, "/c16"}, 2, e, b16.done, b16.busy, b16.S, b16.overflow, b16.zero, es, eo, ez);
      sample_dut({tag, "/c8"},  4, e, b8.done,  b8.busy,  b8.S,  b8.overflow,  b8.zero,  es, eo, ez);
      sample_dut({tag, "/c32"}, 1, e, b32.done, b32.busy, b32.S, b32.overflow, b32.zero, es, eo, ez);
    end
  endtask

  task automatic do_reset();
    t_start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [32:0] es, es2;
    logic        eo, ez, eo2, ez2;
    logic [31:0] a1, b1, a2, b2;

    tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'd5,         32'd7,         33'h0_FFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'd7,         32'd5,         33'h1_0000_0002, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0123_4567, 32'h89AB_CDEF, 33'h0_8ACF_1356, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 33'h1_7FFF_FFFF, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 33'h1_0000_0000, 1'b0, 1'b1};

    t_start = 1'b0; t_sub = 1'b0; t_a = 32'd0; t_b = 32'd0;
    rst_n = 1'b0;
    #1;
    chk("reset busy", {32'd0, b16.busy}, 33'd0);
    chk("reset done", {32'd0, b16.done}, 33'd0);
    chk("reset S", b16.S, 33'd0);
    chk("reset overflow", {32'd0, b16.overflow}, 33'd0);
    chk("reset zero", {32'd0, b16.zero}, 33'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].ovf, tbl[i].zero);
    end

    // start held through RUN with changing operands, then accepted again in DONE
    a1 = 32'hDEAD_BEEF; b1 = 32'h1111_2222;
    a2 = 32'h0000_FFFF; b2 = 32'h0000_0001;
    model(1'b0, a1, b1, es, eo, ez);
    model(1'b1, a2, b2, es2, eo2, ez2);
    t_sub = 1'b0; t_a = a1; t_b = b1; t_start = 1'b1;
    @(posedge clk); #1;
    t_sub = 1'b1; t_a = a2; t_b = b2;
    @(posedge clk); #1;
    chk("held done e2", {32'd0, b16.done}, 33'd0);
    @(posedge clk); #1;
    chk("held done e3", {32'd0, b16.done}, 33'd1);
    chk("held S e3", b16.S, es);
    chk("held ovf e3", {32'd0, b16.overflow}, {32'd0, eo});
    @(posedge clk); #1;
    t_start = 1'b0; t_a = 32'hAAAA_5555; t_b = 32'h5555_AAAA; t_sub = 1'b0;
    chk("b2b done e4", {32'd0, b16.done}, 33'd0);
    chk("b2b busy e4", {32'd0, b16.busy}, 33'd1);
    @(posedge clk); #1;
    chk("b2b done e5", {32'd0, b16.done}, 33'd0);
    @(posedge clk); #1;
    chk("b2b done e6", {32'd0, b16.done}, 33'd1);
    chk("b2b S e6", b16.S, es2);
    chk("b2b zero e6", {32'd0, b16.zero}, {32'd0, ez2});
    do_reset();

    // Reset asserted in the second RUN cycle
    t_sub = 1'b0; t_a = 32'h1234_5678; t_b = 32'h1111_1111; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {32'd0, b16.busy}, 33'd0);
    chk("midrst done", {32'd0, b16.done}, 33'd0);
    chk("midrst S", b16.S, 33'd0);
    chk("midrst overflow", {32'd0, b16.overflow}, 33'd0);
    chk("midrst zero", {32'd0, b16.zero}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      chk("postrst no done", {32'd0, b16.done}, 33'd0);
    end
    run_op("postrst", 1'b0, 32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, 1'b0, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic        rs;
      logic [31:0] ra, rb;
      rs = 1'($urandom_range(1, 0));
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) rb = ra;
      model(rs, ra, rb, es, eo, ez);
      run_op($sformatf("rnd%0d", i), rs, ra, rb, es, eo, ez);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
